// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// Holds the controller state encoding, the {J,K} excitation type and the
// named excitation constants used by jk_excite and jk_excitation_driver.
package jk_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Excitation pair, bit 1 is J and bit 0 is K
  typedef logic [1:0] jk_t;

  localparam jk_t JK_HOLD   = 2'b00;
  localparam jk_t JK_SET    = 2'b10;
  localparam jk_t JK_RESET  = 2'b01;
  localparam jk_t JK_TOGGLE = 2'b11;

  // Set/reset excitation that moves q to t without ever using J=K=1
  function automatic jk_t jk_set_reset(input logic q, input logic t);
    jk_t r;
    case ({q, t})
      2'b01:   r = JK_SET;
      2'b10:   r = JK_RESET;
      default: r = JK_HOLD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit excitation generator: purely combinational, maps the current Q
// and the target bit to the {J,K} pair that moves Q to the target.
// Build option: define JK_TOGGLE_EN to use toggle (J=K=1) for changing bits;
// without it only set/reset excitation is produced.
import jk_pkg::*;

module jk_excite (
  input  logic i_q,
  input  logic i_tgt,
  output jk_t  o_jk
);

  // Choose the excitation for one flip-flop; unchanged bits always hold
  always_comb begin
    o_jk = JK_HOLD;
    if (i_q != i_tgt) begin
`ifdef JK_TOGGLE_EN
      o_jk = JK_TOGGLE;
`else
      o_jk = jk_set_reset(i_q, i_tgt);
`endif
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: accepts a target word, pulses J/K excitations for
// one cycle, waits SETTLE cycles, then checks the fed-back Q and retries up
// to MAX_RETRY times before flagging an error.
// Build option: JK_TOGGLE_EN (toggle excitation for changing bits).
import jk_pkg::*;

module jk_excitation_driver #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Counter widths; both stay at least one bit wide for the degenerate cases
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // WAIT is entered with SETTLE-1 and left when the count reaches zero
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [RW-1:0]    r_retry;
  logic [SW-1:0]    r_settle;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_tgt_sel;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  jk_t              w_jk [WIDTH];
  logic             w_accept;
  logic             w_match;

  // In IDLE the excitation is computed against the incoming word so it can
  // be registered on the accepting edge; on retries the held target is used.
  assign w_tgt_sel = (r_state == IDLE) ? tgt_data : r_tgt;
  assign w_accept  = tgt_valid && r_ready;
  assign w_match   = (q_fb == r_tgt);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_excite u_excite (
        .i_q   (q_fb[gi]),
        .i_tgt (w_tgt_sel[gi]),
        .o_jk  (w_jk[gi])
      );
      assign w_j[gi] = w_jk[gi][1];
      assign w_k[gi] = w_jk[gi][0];
    end
  endgenerate

  // Controller FSM; every output is registered and excitations default to
  // zero so they are only non-zero for the single DRIVE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tgt    <= '0;
      r_retry  <= '0;
      r_settle <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_j    <= '0;
      r_k    <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tgt   <= tgt_data;
            r_retry <= '0;
            r_j     <= w_j;
            r_k     <= w_k;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= DRIVE;
          end else begin
            // Ready rises one cycle after reset releases
            r_ready <= 1'b1;
          end
        end
        DRIVE: begin
          r_settle <= SETTLE_LOAD;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_settle == '0) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        CHECK: begin
          if (w_match) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + 1'b1;
            r_j     <= w_j;
            r_k     <= w_k;
            r_state <= DRIVE;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tgt_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign j_out     = r_j;
  assign k_out     = r_k;

endmodule
